// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage boundaries: bundle widths, control bit map, counter helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package pipe_pkg;

    // Per-boundary bundle widths
    localparam int unsigned ID_EX_CTRL_W  = 12;
    localparam int unsigned ID_EX_DATA_W  = 24;
    localparam int unsigned EX_MEM_CTRL_W = 12;
    localparam int unsigned EX_MEM_DATA_W = 24;
    localparam int unsigned MEM_WB_CTRL_W = 12;
    localparam int unsigned MEM_WB_DATA_W = 24;

    // Bit positions of the control fields inside the control bundle
    localparam int unsigned CTRL_CPIN         = 0;
    localparam int unsigned CTRL_CPOUT        = 1;
    localparam int unsigned CTRL_MEMREAD      = 2;
    localparam int unsigned CTRL_MEMWRITE     = 3;
    localparam int unsigned CTRL_WRITESRC_LSB = 4;   // two bits: [5:4]
    localparam int unsigned CTRL_HALT         = 6;
    localparam int unsigned CTRL_BRANCH       = 7;
    localparam int unsigned CTRL_JUMP         = 8;
    localparam int unsigned CTRL_REGWRITE     = 9;

    // Adds inc to cur and clamps at the all-ones value of a w-bit counter (w <= 32)
    function automatic logic [31:0] sat_inc(input logic [31:0] cur,
                                            input logic [1:0]  inc,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max;
        max = (33'd1 << w) - 33'd1;
        sum = {1'b0, cur} + {31'b0, inc};
        return (sum > max) ? max[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying one control word and one data word.
// Latency: n/a (wiring only).
// Backpressure: ready from the slave side throttles valid from the master side.
interface pipe_stage_skid_if #(
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned DATA_W = 24
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input  ready);
    modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter, adds 0..3 per cycle and sticks at all-ones.
// Latency: count reflects inc one cycle after it is presented.
// Backpressure: none.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [1:0]   inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next value: clamped sum
    always_comb begin
        count_d = W'(sat_inc(32'(count_q), inc, W));
    end

    // Counter register with synchronous clear
    always_ff @(posedge clock) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline boundary register with 2-entry skid, flush-to-bubble and stall/drop counters.
// Latency: 1 cycle from accept to out_valid; 1 entry/cycle sustained.
// Backpressure: in_ready is registered, drops the cycle after the skid fills, no comb path from out_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W              = ID_EX_CTRL_W,
    parameter int unsigned DATA_W              = ID_EX_DATA_W,
    parameter int unsigned CNT_W               = 16,
    parameter bit          CLEAR_DATA_ON_FLUSH = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    pipe_stage_skid_if.slave     up,
    pipe_stage_skid_if.master    dn,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     drop_cnt
);
    logic              main_vld_q,  main_vld_d;
    logic              skid_vld_q,  skid_vld_d;
    logic              in_ready_q,  in_ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic       acc;
    logic       pop;
    logic       stalled;
    logic [1:0] stall_inc;
    logic [1:0] drop_inc;

    assign acc     = up.valid & in_ready_q;
    assign pop     = main_vld_q & dn.ready;
    assign stalled = main_vld_q & ~dn.ready;

    // Next-state of main/skid entries; ctrl is cleared whenever its valid drops so bubbles are inert
    always_comb begin
        main_vld_d  = main_vld_q;
        skid_vld_d  = skid_vld_q;
        main_ctrl_d = main_ctrl_q;
        skid_ctrl_d = skid_ctrl_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            main_vld_d  = 1'b0;
            skid_vld_d  = 1'b0;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLEAR_DATA_ON_FLUSH) main_data_d = '0;
        end else if (skid_vld_q) begin
            // Full: in_ready is low so only a pop can move things
            if (pop) begin
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_vld_d  = 1'b0;
                skid_ctrl_d = '0;
            end
        end else if (main_vld_q) begin
            if (acc && pop) begin
                main_ctrl_d = up.ctrl;
                main_data_d = up.data;
            end else if (acc) begin
                skid_vld_d  = 1'b1;
                skid_ctrl_d = up.ctrl;
                skid_data_d = up.data;
            end else if (pop) begin
                main_vld_d  = 1'b0;
                main_ctrl_d = '0;
            end
        end else if (acc) begin
            main_vld_d  = 1'b1;
            main_ctrl_d = up.ctrl;
            main_data_d = up.data;
        end
        in_ready_d = ~(main_vld_d & skid_vld_d);
    end

    // Stage state registers; reset overrides flush and handshakes
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            main_vld_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            main_data_q <= '0;
            skid_data_q <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            skid_vld_q  <= skid_vld_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            skid_ctrl_q <= skid_ctrl_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Counter increments: a popped entry still leaves cleanly during flush, so it is not a drop
    always_comb begin
        stall_inc = {1'b0, stalled};
        drop_inc  = 2'b00;
        if (flush) drop_inc = 2'(stalled) + 2'(skid_vld_q) + 2'(acc);
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (stall_inc),
        .count   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (drop_inc),
        .count   (drop_cnt)
    );

    assign up.ready = in_ready_q;
    assign dn.valid = main_vld_q;
    assign dn.ctrl  = main_ctrl_q;
    assign dn.data  = main_data_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed steps then random traffic against a queue-based model.
// Latency: model output is compared 1 time unit after each rising edge.
// Backpressure: out_ready driven directly from the sequence.
module tb_pipe_stage_skid;
    localparam int unsigned CW  = 12;
    localparam int unsigned DW  = 24;
    localparam int unsigned NW  = 4;
    localparam int          MAXC = (1 << NW) - 1;

    logic          clock;
    logic          reset_n;
    logic          flush;
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] drop_cnt;

    pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) up_if ();
    pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) dn_if ();

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW), .CLEAR_DATA_ON_FLUSH(1'b0)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .up        (up_if.slave),
        .dn        (dn_if.master),
        .stall_cnt (stall_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;

    // Reference model: the stage is a FIFO of up to two entries
    logic [CW-1:0] mq_c[$];
    logic [DW-1:0] mq_d[$];
    logic          m_rdy   = 1'b1;
    logic [DW-1:0] m_odata = '0;
    int            m_stall = 0;
    int            m_drop  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [CW-1:0] exp_c;
        exp_c = (mq_c.size() > 0) ? mq_c[0] : '0;
        chk({tag, ".out_valid"}, 32'(dn_if.valid), 32'(mq_c.size() > 0));
        chk({tag, ".out_ctrl"},  32'(dn_if.ctrl),  32'(exp_c));
        chk({tag, ".out_data"},  32'(dn_if.data),  32'(m_odata));
        chk({tag, ".in_ready"},  32'(up_if.ready), 32'(m_rdy));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt),   32'(m_stall));
        chk({tag, ".drop_cnt"},  32'(drop_cnt),    32'(m_drop));
    endtask

    // Drive one cycle of inputs, advance the model, clock the DUT, compare
    task automatic step(input string tag, input logic rst_n, input logic v, input logic fl,
                        input logic ordy, input logic [CW-1:0] c, input logic [DW-1:0] d);
        int acc;
        int pop;
        reset_n     = rst_n;
        up_if.valid = v;
        up_if.ctrl  = c;
        up_if.data  = d;
        flush       = fl;
        dn_if.ready = ordy;
        if (!rst_n) begin
            mq_c.delete();
            mq_d.delete();
            m_rdy = 1'b1; m_odata = '0; m_stall = 0; m_drop = 0;
        end else begin
            acc = (v && m_rdy) ? 1 : 0;
            pop = (mq_c.size() > 0 && ordy) ? 1 : 0;
            if (mq_c.size() > 0 && !ordy) m_stall = (m_stall + 1 > MAXC) ? MAXC : m_stall + 1;
            if (fl) begin
                m_drop = m_drop + (mq_c.size() - pop) + acc;
                if (m_drop > MAXC) m_drop = MAXC;
                mq_c.delete();
                mq_d.delete();
                m_rdy = 1'b1;
            end else begin
                if (pop == 1) begin
                    void'(mq_c.pop_front());
                    void'(mq_d.pop_front());
                end
                if (acc == 1) begin
                    mq_c.push_back(c);
                    mq_d.push_back(d);
                end
                m_rdy = (mq_c.size() < 2);
                if (mq_c.size() > 0) m_odata = mq_d[0];
            end
        end
        @(posedge clock);
        #1;
        check_model(tag);
    endtask

    initial begin
        int d0;
        reset_n = 1'b0; flush = 1'b0;
        up_if.valid = 1'b0; up_if.ctrl = '0; up_if.data = '0;
        dn_if.ready = 1'b0;
        #2;

        // Reset held two cycles with valid and flush asserted
        step("rst0", 1'b0, 1'b1, 1'b1, 1'b1, 12'hABC, 24'h123456);
        step("rst1", 1'b0, 1'b1, 1'b1, 1'b1, 12'hABC, 24'h123456);
        chk("rst.in_ready", 32'(up_if.ready), 32'd1);
        chk("rst.out_ctrl", 32'(dn_if.ctrl), 32'd0);

        // First accept after reset appears one cycle later
        step("first", 1'b1, 1'b1, 1'b0, 1'b1, 12'h3A5, 24'h0A0A0A);
        chk("first.out_ctrl", 32'(dn_if.ctrl), 32'h3A5);

        // Back-to-back streaming
        for (int i = 1; i <= 8; i++) begin
            step("stream", 1'b1, 1'b1, 1'b0, 1'b1, 12'(i), 24'(i * 16));
            chk("stream.ctrl", 32'(dn_if.ctrl), 32'(i));
            chk("stream.rdy", 32'(up_if.ready), 32'd1);
        end
        step("drain", 1'b1, 1'b0, 1'b0, 1'b1, 12'h0, 24'h0);
        chk("stream.stall", 32'(stall_cnt), 32'd0);

        // Backpressure into the skid
        step("bp11", 1'b1, 1'b1, 1'b0, 1'b0, 12'h011, 24'h000011);
        step("bp22", 1'b1, 1'b1, 1'b0, 1'b0, 12'h022, 24'h000022);
        chk("bp.in_ready_low", 32'(up_if.ready), 32'd0);
        step("bp33a", 1'b1, 1'b1, 1'b0, 1'b0, 12'h033, 24'h000033);
        step("bp33b", 1'b1, 1'b1, 1'b0, 1'b0, 12'h033, 24'h000033);
        chk("bp.stall3", 32'(stall_cnt), 32'd3);
        chk("bp.hold11", 32'(dn_if.ctrl), 32'h011);
        step("rel1", 1'b1, 1'b1, 1'b0, 1'b1, 12'h033, 24'h000033);
        chk("rel.22", 32'(dn_if.ctrl), 32'h022);
        step("rel2", 1'b1, 1'b1, 1'b0, 1'b1, 12'h033, 24'h000033);
        chk("rel.33", 32'(dn_if.ctrl), 32'h033);
        step("rel3", 1'b1, 1'b0, 1'b0, 1'b1, 12'h0, 24'h0);

        // Flush in TWO: main + skid dropped
        step("f2a", 1'b1, 1'b1, 1'b0, 1'b0, 12'h0A1, 24'h0000A1);
        step("f2b", 1'b1, 1'b1, 1'b0, 1'b0, 12'h0A2, 24'h0000A2);
        d0 = int'(drop_cnt);
        step("f2fl", 1'b1, 1'b0, 1'b1, 1'b0, 12'h0, 24'h0);
        chk("flushTWO.drop", 32'(drop_cnt), 32'(d0 + 2));
        chk("flushTWO.ctrl", 32'(dn_if.ctrl), 32'd0);

        // Flush in ONE with a simultaneous accept
        step("f1a", 1'b1, 1'b1, 1'b0, 1'b0, 12'h0B1, 24'h0000B1);
        d0 = int'(drop_cnt);
        step("f1fl", 1'b1, 1'b1, 1'b1, 1'b0, 12'h0B2, 24'h0000B2);
        chk("flushONE.drop", 32'(drop_cnt), 32'(d0 + 2));
        chk("flushONE.rdy", 32'(up_if.ready), 32'd1);

        // Flush with a pop in ONE: no drop
        step("fpa", 1'b1, 1'b1, 1'b0, 1'b1, 12'h0C1, 24'h0000C1);
        chk("flushPOP.seen", 32'(dn_if.ctrl), 32'h0C1);
        d0 = int'(drop_cnt);
        step("fpfl", 1'b1, 1'b0, 1'b1, 1'b1, 12'h0, 24'h0);
        chk("flushPOP.drop", 32'(drop_cnt), 32'(d0));

        // Stall saturation, then reset mid-stall
        step("sat0", 1'b1, 1'b1, 1'b0, 1'b0, 12'h055, 24'h000055);
        for (int i = 0; i < 20; i++) step("sat", 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 24'h0);
        chk("sat.stall", 32'(stall_cnt), 32'hF);
        step("satrst", 1'b0, 1'b1, 1'b0, 1'b0, 12'h077, 24'h000077);
        chk("satrst.valid", 32'(dn_if.valid), 32'd0);
        chk("satrst.stall", 32'(stall_cnt), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 12'($urandom),
                 24'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
